// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_pkg                                                                   |
// | Shared physical-register and issue-queue entry types.                    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package cpu_pkg;

    localparam int PREG_W    = 6;
    localparam int NUM_PREGS = 64;
    localparam int PAYLOAD_W = 32;

    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        logic                 valid;
        preg_t                phys_rd;
        preg_t                phys_rs1;
        logic                 rdy1;
        preg_t                phys_rs2;
        logic                 rdy2;
        logic [PAYLOAD_W-1:0] payload;
    } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/phys_ready_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | phys_ready_table                                                          |
// | Per-physical-register ready bits: set by writeback, cleared by dispatch. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module phys_ready_table #(
    parameter int NUM_PREGS = 64,
    parameter int PREG_W    = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic [PREG_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [PREG_W-1:0] clr_idx,
    input  logic [PREG_W-1:0] rd_idx_a,
    input  logic [PREG_W-1:0] rd_idx_b,
    output logic              rdy_a,
    output logic              rdy_b
);

    logic [NUM_PREGS-1:0] r_ready;

    // The clear is written last so a same-edge dispatch to the register wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= '1;
        end else begin
            if (set_en) begin
                r_ready[set_idx] <= 1'b1;
            end
            if (clr_en) begin
                r_ready[clr_idx] <= 1'b0;
            end
        end
    end

    assign rdy_a = r_ready[rd_idx_a];
    assign rdy_b = r_ready[rd_idx_b];

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_queue                                                               |
// | Collapsing in-order-allocated, oldest-ready-first issue queue.           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = 6,
    parameter int NUM_PREGS = 64,
    parameter int PAYLOAD_W = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  logic [PREG_W-1:0]          dispatch_phys_rd,
    input  logic [PREG_W-1:0]          dispatch_phys_rs1,
    input  logic [PREG_W-1:0]          dispatch_phys_rs2,
    input  logic [PAYLOAD_W-1:0]       dispatch_payload,
    output logic                       iq_issue_valid,
    input  logic                       iq_issue_ready,
    output logic [PREG_W-1:0]          iq_issue_phys_rd,
    output logic [PREG_W-1:0]          iq_issue_phys_rs1,
    output logic [PREG_W-1:0]          iq_issue_phys_rs2,
    output logic [PAYLOAD_W-1:0]       iq_issue_payload,
    input  logic                       wb_valid,
    input  logic [PREG_W-1:0]          wb_phys_rd,
    output logic [$clog2(DEPTH+1)-1:0] iq_count,
    output logic                       iq_full
);

    import cpu_pkg::iq_entry_t;

    localparam int                 c_CNT_W = $clog2(DEPTH+1);
    localparam int                 c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    iq_entry_t          r_entries [DEPTH];
    logic [c_CNT_W-1:0] r_count;

    iq_entry_t          w_ext  [DEPTH+1];
    iq_entry_t          w_next [DEPTH];
    iq_entry_t          w_e;
    iq_entry_t          w_sel_entry;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic               w_sel_found;
    logic               w_issue_fire;
    logic               w_dispatch_fire;
    logic [c_CNT_W-1:0] w_wr_idx;
    logic               w_tbl_rdy1;
    logic               w_tbl_rdy2;
    logic               w_cap_rdy1;
    logic               w_cap_rdy2;

    phys_ready_table #(
        .NUM_PREGS (NUM_PREGS),
        .PREG_W    (PREG_W)
    ) u_ready_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (wb_valid),
        .set_idx  (wb_phys_rd),
        .clr_en   (w_dispatch_fire && !flush),
        .clr_idx  (dispatch_phys_rd),
        .rd_idx_a (dispatch_phys_rs1),
        .rd_idx_b (dispatch_phys_rs2),
        .rdy_a    (w_tbl_rdy1),
        .rdy_b    (w_tbl_rdy2)
    );

    assign dispatch_ready  = (r_count < c_DEPTH);
    assign iq_full         = (r_count == c_DEPTH);
    assign iq_count        = r_count;
    assign w_dispatch_fire = dispatch_valid && dispatch_ready;
    assign w_issue_fire    = w_sel_found && iq_issue_ready;

    // A writeback in the dispatch cycle is not yet in the table, so bypass it.
    assign w_cap_rdy1 = w_tbl_rdy1 || (wb_valid && (wb_phys_rd == dispatch_phys_rs1));
    assign w_cap_rdy2 = w_tbl_rdy2 || (wb_valid && (wb_phys_rd == dispatch_phys_rs2));

    // Scanning from the top down leaves the lowest (oldest) ready index.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (r_entries[i].valid && r_entries[i].rdy1 && r_entries[i].rdy2) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_IDX_W'(i);
            end
        end
    end

    assign w_sel_entry       = r_entries[w_sel_idx];
    assign iq_issue_valid    = w_sel_found;
    assign iq_issue_phys_rd  = w_sel_found ? w_sel_entry.phys_rd  : '0;
    assign iq_issue_phys_rs1 = w_sel_found ? w_sel_entry.phys_rs1 : '0;
    assign iq_issue_phys_rs2 = w_sel_found ? w_sel_entry.phys_rs2 : '0;
    assign iq_issue_payload  = w_sel_found ? w_sel_entry.payload  : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ext[i] = r_entries[i];
        end
        w_ext[DEPTH] = '0;
        w_wr_idx     = r_count - c_CNT_W'(w_issue_fire);
        w_e          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Collapse: everything above the issued slot moves down one.
            if (w_issue_fire && (c_IDX_W'(i) >= w_sel_idx)) begin
                w_e = w_ext[i+1];
            end else begin
                w_e = w_ext[i];
            end
            if (wb_valid && w_e.valid && (w_e.phys_rs1 == wb_phys_rd)) begin
                w_e.rdy1 = 1'b1;
            end
            if (wb_valid && w_e.valid && (w_e.phys_rs2 == wb_phys_rd)) begin
                w_e.rdy2 = 1'b1;
            end
            if (w_dispatch_fire && (c_CNT_W'(i) == w_wr_idx)) begin
                w_e.valid    = 1'b1;
                w_e.phys_rd  = dispatch_phys_rd;
                w_e.phys_rs1 = dispatch_phys_rs1;
                w_e.rdy1     = w_cap_rdy1;
                w_e.phys_rs2 = dispatch_phys_rs2;
                w_e.rdy2     = w_cap_rdy2;
                w_e.payload  = dispatch_payload;
            end
            w_next[i] = w_e;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_entries <= '{default: '0};
            r_count   <= '0;
        end else if (flush) begin
            r_entries <= '{default: '0};
            r_count   <= '0;
        end else begin
            r_entries <= w_next;
            r_count   <= r_count + c_CNT_W'(w_dispatch_fire) - c_CNT_W'(w_issue_fire);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_issue_queue                                                            |
// | Directed scenarios plus random traffic against a queue-based model.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_issue_queue;

    localparam int DEPTH     = 8;
    localparam int PREG_W    = 6;
    localparam int NUM_PREGS = 64;
    localparam int PAYLOAD_W = 32;
    localparam int CNT_W     = $clog2(DEPTH+1);

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 flush;
    logic                 dispatch_valid;
    logic                 dispatch_ready;
    logic [PREG_W-1:0]    dispatch_phys_rd;
    logic [PREG_W-1:0]    dispatch_phys_rs1;
    logic [PREG_W-1:0]    dispatch_phys_rs2;
    logic [PAYLOAD_W-1:0] dispatch_payload;
    logic                 iq_issue_valid;
    logic                 iq_issue_ready;
    logic [PREG_W-1:0]    iq_issue_phys_rd;
    logic [PREG_W-1:0]    iq_issue_phys_rs1;
    logic [PREG_W-1:0]    iq_issue_phys_rs2;
    logic [PAYLOAD_W-1:0] iq_issue_payload;
    logic                 wb_valid;
    logic [PREG_W-1:0]    wb_phys_rd;
    logic [CNT_W-1:0]     iq_count;
    logic                 iq_full;

    always #5 clk = ~clk;

    issue_queue #(
        .DEPTH     (DEPTH),
        .PREG_W    (PREG_W),
        .NUM_PREGS (NUM_PREGS),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush             (flush),
        .dispatch_valid    (dispatch_valid),
        .dispatch_ready    (dispatch_ready),
        .dispatch_phys_rd  (dispatch_phys_rd),
        .dispatch_phys_rs1 (dispatch_phys_rs1),
        .dispatch_phys_rs2 (dispatch_phys_rs2),
        .dispatch_payload  (dispatch_payload),
        .iq_issue_valid    (iq_issue_valid),
        .iq_issue_ready    (iq_issue_ready),
        .iq_issue_phys_rd  (iq_issue_phys_rd),
        .iq_issue_phys_rs1 (iq_issue_phys_rs1),
        .iq_issue_phys_rs2 (iq_issue_phys_rs2),
        .iq_issue_payload  (iq_issue_payload),
        .wb_valid          (wb_valid),
        .wb_phys_rd        (wb_phys_rd),
        .iq_count          (iq_count),
        .iq_full           (iq_full)
    );

    // Model: age-ordered list of waiting instructions plus a ready bit per register.
    typedef struct {
        bit [PREG_W-1:0]    rd;
        bit [PREG_W-1:0]    rs1;
        bit [PREG_W-1:0]    rs2;
        bit                 r1;
        bit                 r2;
        bit [PAYLOAD_W-1:0] pl;
    } ment_t;

    ment_t mq[$];
    bit    mtbl [NUM_PREGS];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msel();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NUM_PREGS; i++) mtbl[i] = 1'b1;
    endtask

    task automatic model_compare();
        int s;
        s = msel();
        chk("count", 64'(iq_count), 64'(mq.size()));
        chk("dispatch_ready", 64'(dispatch_ready), 64'(mq.size() < DEPTH));
        chk("full", 64'(iq_full), 64'(mq.size() == DEPTH));
        chk("issue_valid", 64'(iq_issue_valid), 64'(s >= 0));
        if (s >= 0) begin
            chk("issue_rd", 64'(iq_issue_phys_rd), 64'(mq[s].rd));
            chk("issue_rs1", 64'(iq_issue_phys_rs1), 64'(mq[s].rs1));
            chk("issue_rs2", 64'(iq_issue_phys_rs2), 64'(mq[s].rs2));
            chk("issue_payload", 64'(iq_issue_payload), 64'(mq[s].pl));
        end else begin
            chk("idle_fields", {iq_issue_phys_rd, iq_issue_phys_rs1, iq_issue_phys_rs2, iq_issue_payload}, 64'd0);
        end
    endtask

    task automatic model_update();
        int    s;
        bit    dfire;
        bit    ifire;
        ment_t e;
        if (!reset_n) begin
            model_reset();
            return;
        end
        s     = msel();
        dfire = dispatch_valid && (mq.size() < DEPTH);
        ifire = (s >= 0) && iq_issue_ready;
        e.rd  = dispatch_phys_rd;
        e.rs1 = dispatch_phys_rs1;
        e.rs2 = dispatch_phys_rs2;
        e.pl  = dispatch_payload;
        e.r1  = mtbl[dispatch_phys_rs1] || (wb_valid && wb_phys_rd == dispatch_phys_rs1);
        e.r2  = mtbl[dispatch_phys_rs2] || (wb_valid && wb_phys_rd == dispatch_phys_rs2);
        if (flush) begin
            mq.delete();
        end else begin
            if (ifire) mq.delete(s);
            if (wb_valid) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].rs1 == wb_phys_rd) mq[i].r1 = 1'b1;
                    if (mq[i].rs2 == wb_phys_rd) mq[i].r2 = 1'b1;
                end
            end
            if (dfire) mq.push_back(e);
        end
        if (wb_valid) mtbl[wb_phys_rd] = 1'b1;
        if (dfire && !flush) mtbl[dispatch_phys_rd] = 1'b0;
    endtask

    // Entered and left at posedge+1; inputs are changed only between steps.
    task automatic step();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic disp(input bit v, input int rd, input int rs1, input int rs2);
        dispatch_valid    = v;
        dispatch_phys_rd  = PREG_W'(rd);
        dispatch_phys_rs1 = PREG_W'(rs1);
        dispatch_phys_rs2 = PREG_W'(rs2);
        dispatch_payload  = $urandom;
    endtask

    task automatic wb(input bit v, input int rd);
        wb_valid   = v;
        wb_phys_rd = PREG_W'(rd);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 64'(iq_count), 64'd0);
        chk({tag, "_dready"}, 64'(dispatch_ready), 64'd1);
        chk({tag, "_ivalid"}, 64'(iq_issue_valid), 64'd0);
        chk({tag, "_full"}, 64'(iq_full), 64'd0);
        chk({tag, "_fields"}, {iq_issue_phys_rd, iq_issue_phys_rs1, iq_issue_phys_rs2, iq_issue_payload}, 64'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        flush          = 1'b0;
        iq_issue_ready = 1'b0;
        disp(0, 0, 0, 0);
        wb(0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: independent instruction issues the cycle after dispatch
        iq_issue_ready = 1'b1;
        disp(1, 33, 1, 2);
        step();
        chk("t1_count1", 64'(iq_count), 64'd1);
        chk("t1_rd", 64'(iq_issue_phys_rd), 64'd33);
        disp(0, 0, 0, 0);
        step();
        chk("t1_count0", 64'(iq_count), 64'd0);

        // 2: B waits on A's destination until its writeback
        disp(1, 40, 1, 2);
        step();
        disp(1, 41, 40, 3);
        step();
        disp(0, 0, 0, 0);
        iq_issue_ready = 1'b0;
        chk("t2_b_blocked", 64'(iq_issue_valid), 64'd0);
        step();
        chk("t2_b_still_blocked", 64'(iq_issue_valid), 64'd0);
        wb(1, 40);
        step();
        wb(0, 0);
        chk("t2_b_woken", 64'(iq_issue_valid), 64'd1);
        chk("t2_b_rd", 64'(iq_issue_phys_rd), 64'd41);
        step();
        chk("t2_b_held", 64'(iq_issue_phys_rd), 64'd41);
        iq_issue_ready = 1'b1;
        step();
        chk("t2_empty", 64'(iq_count), 64'd0);

        // 3: same-cycle writeback bypass at dispatch
        disp(1, 45, 1, 2);
        step();
        disp(0, 0, 0, 0);
        step();
        disp(1, 50, 45, 2);
        wb(1, 45);
        iq_issue_ready = 1'b0;
        step();
        disp(0, 0, 0, 0);
        wb(0, 0);
        chk("t3_bypass_valid", 64'(iq_issue_valid), 64'd1);
        chk("t3_bypass_rd", 64'(iq_issue_phys_rd), 64'd50);
        iq_issue_ready = 1'b1;
        step();

        // 4: fill to full, refuse a 9th, then drain oldest first
        disp(1, 60, 1, 2);
        step();
        for (int k = 0; k < DEPTH; k++) begin
            disp(1, 10 + k, 60, 2);
            step();
        end
        chk("t4_full", 64'(iq_full), 64'd1);
        chk("t4_dready", 64'(dispatch_ready), 64'd0);
        disp(1, 30, 1, 2);
        step();
        chk("t4_count_held", 64'(iq_count), 64'd8);
        disp(0, 0, 0, 0);
        wb(1, 60);
        step();
        wb(0, 0);
        for (int k = 0; k < DEPTH; k++) begin
            chk("t4_drain_rd", 64'(iq_issue_phys_rd), 64'(10 + k));
            chk("t4_drain_count", 64'(iq_count), 64'(DEPTH - k));
            step();
        end
        chk("t4_drained", 64'(iq_count), 64'd0);

        // 5: youngest-ready issues first, older ones keep order
        disp(1, 22, 10, 2);
        step();
        disp(1, 23, 11, 2);
        step();
        disp(1, 24, 1, 2);
        step();
        disp(0, 0, 0, 0);
        chk("t5_young_rd", 64'(iq_issue_phys_rd), 64'd24);
        chk("t5_count3", 64'(iq_count), 64'd3);
        step();
        chk("t5_none_ready", 64'(iq_issue_valid), 64'd0);
        wb(1, 10);
        step();
        wb(0, 0);
        chk("t5_entry0_rd", 64'(iq_issue_phys_rd), 64'd22);
        step();
        wb(1, 11);
        step();
        wb(0, 0);
        chk("t5_entry1_rd", 64'(iq_issue_phys_rd), 64'd23);
        step();

        // 6: flush with a dispatch in the same cycle, then async reset mid-cycle
        for (int k = 0; k < 5; k++) begin
            disp(1, 25 + k, 12, 2);
            step();
        end
        chk("t6_count5", 64'(iq_count), 64'd5);
        flush = 1'b1;
        disp(1, 31, 1, 2);
        step();
        flush = 1'b0;
        disp(0, 0, 0, 0);
        chk("t6_flushed_count", 64'(iq_count), 64'd0);
        chk("t6_flushed_valid", 64'(iq_issue_valid), 64'd0);
        disp(1, 33, 13, 2);
        step();
        disp(1, 34, 1, 2);
        step();
        disp(0, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        model_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        iq_issue_ready = 1'b0;
        disp(1, 5, 50, 41);
        step();
        disp(0, 0, 0, 0);
        chk("t6_table_reset_valid", 64'(iq_issue_valid), 64'd1);
        chk("t6_table_reset_rd", 64'(iq_issue_phys_rd), 64'd5);

        // Random traffic over a small register window to force dependencies
        for (int n = 0; n < 3000; n++) begin
            disp(($urandom_range(0, 99) < 60), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
            wb(($urandom_range(0, 99) < 40), $urandom_range(0, 15));
            iq_issue_ready = ($urandom_range(0, 99) < 70);
            flush          = ($urandom_range(0, 99) < 2);
            step();
        end
        flush = 1'b0;
        disp(0, 0, 0, 0);
        wb(0, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_queue.md
Name: issue_queue

Overview:
Unified, in-order-allocated, out-of-order-issuing instruction queue. It sits directly downstream of the rename stage and accepts renamed instructions as phys_rd, phys_rs1, phys_rs2 plus an opaque payload. It tracks operand readiness with a physical-register ready table that is woken by writeback broadcasts. Each cycle it issues the oldest instruction whose sources are both ready to the execute stage.

Parameters:
DEPTH, 8, number of queue entries (power of 2 not required, at least 2)
PREG_W, 6, physical register index width
NUM_PREGS, 64, physical registers tracked by the ready table (equals 2**PREG_W)
PAYLOAD_W, 32, opaque per-instruction payload width (opcode, imm, ROB tag)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; clears all queue entries
dispatch_valid  in  1  renamed instruction present
dispatch_ready  out  1  queue can accept (count < DEPTH)
dispatch_phys_rd  in  PREG_W  destination physical register
dispatch_phys_rs1  in  PREG_W  source 1 physical register
dispatch_phys_rs2  in  PREG_W  source 2 physical register
dispatch_payload  in  PAYLOAD_W  carried unmodified
iq_issue_valid  out  1  selected entry ready to issue
iq_issue_ready  in  1  execute stage accepts
iq_issue_phys_rd / _rs1 / _rs2  out  PREG_W each  selected entry fields
iq_issue_payload  out  PAYLOAD_W  selected entry payload
wb_valid  in  1  writeback broadcast
wb_phys_rd  in  PREG_W  register produced
iq_count  out  $clog2(DEPTH+1)  occupied entries
iq_full  out  1  count == DEPTH

Behaviour:
- Reset (async, reset_n=0): all entries invalid; count=0; ready table all 1s; dispatch_ready=1; iq_issue_valid=0; issue data outputs 0; iq_full=0.
- Storage: collapsing queue. Entry 0 is oldest; valid entries stay contiguous from index 0.
- Dispatch handshake: accepted on a rising edge when dispatch_valid && dispatch_ready. dispatch_ready depends only on registered count and does not credit a same-cycle issue.
- Dispatch writes at index count, or count-1 if an issue occurs in the same cycle. It captures src ready bits = table[rs] OR (wb_valid && wb_phys_rd==rs).
- Dispatch clears table[phys_rd] at the edge.
- Writeback sets table[wb_phys_rd] at the edge and sets the matching src ready bits in all valid entries.
- Same-cycle writeback and dispatch to the same register: dispatch wins, and the table bit ends at 0.
- Select: combinational. Choose the lowest index with valid && rdy1 && rdy2. iq_issue_valid is high if such an entry exists; output fields come from that entry. When no entry is selected, output fields are 0.
- Issue handshake: on iq_issue_valid && iq_issue_ready, the selected entry is removed at the edge and entries above it shift down by one.
- Latency: a dispatched entry is selectable no earlier than the cycle after acceptance. A writeback at edge N makes the dependent entry selectable in cycle N+1 (one-cycle wakeup).
- The queue holds iq_issue_* stable while iq_issue_valid && !iq_issue_ready, unless an older entry becomes ready, in which case the older entry is selected.
- Count: count_next = count + dispatch_fire - issue_fire.
- Full, with issue in the same cycle: dispatch is refused that cycle because dispatch_ready=0.
- Empty: iq_issue_valid=0.
- flush: all entries invalid and count=0 at the edge; the ready table is untouched. Dispatch and issue in the flush cycle are discarded. flush has priority over everything except reset.
- Reset mid-operation: full return to the reset state, including the ready table.

Decomposition:
- Shared package cpu_pkg holds:
  - preg_t (logic [PREG_W-1:0])
  - iq_entry_t struct {valid, phys_rd, phys_rs1, rdy1, phys_rs2, rdy2, payload}
  - constants NUM_PREGS, PREG_W
- Sub-module phys_ready_table: NUM_PREGS-bit register with set (wb) and clear (dispatch) ports, two combinational lookups, and clear-over-set priority.

Test Plan:
1. Reset, then dispatch rd=33, rs1=1, rs2=2. The entry issues the next cycle with iq_issue_phys_rd=33; count goes 0→1→0.
2. Dispatch A (rd=40, rs1=1, rs2=2) then B (rd=41, rs1=40, rs2=3), holding iq_issue_ready=0 after A issues. B is not valid until wb_phys_rd=40 at edge N; B has iq_issue_valid=1 in cycle N+1.
3. Dispatch rd=50 waiting on rs1=45, which was cleared by a prior dispatch. In the same cycle drive wb_valid=1, wb_phys_rd=45. The entry captures rdy1=1 and issues the next cycle (bypass).
4. Dispatch 8 instructions dependent on rs1=60 (not ready). Then iq_full=1, dispatch_ready=0, and a 9th dispatch is ignored with count held at 8. A writeback of 60 releases entries in order, oldest first, one per cycle.
5. Fill 3 entries where only entry 2 is ready. It issues first, and entries 0 and 1 stay in order without shifting. Next, wb readies entry 0, which issues before entry 1.
6. With 5 entries queued, assert flush. Next cycle count=0 and iq_issue_valid=0. Then pulse reset_n=0 asynchronously mid-cycle: outputs go to reset values immediately and the ready table reads all 1s.
